// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller: accepts a signed operand pair, runs one
// Booth step per clock for WIDTH clocks, then holds the 2*WIDTH-bit product until it is taken.
module booth_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2*WIDTH-1:0]             y,
  output logic [$clog2(WIDTH+1)-1:0]     step
);

  localparam int SW = $clog2(WIDTH+1);
  localparam logic [SW-1:0] STEP_LAST = SW'(WIDTH-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // A carries one guard bit so that subtracting M = -2^(WIDTH-1) never wraps.
  logic [WIDTH:0]        r_a;
  logic [WIDTH:0]        r_m;
  logic [WIDTH-1:0]      r_q;
  logic                  r_q0;
  logic [SW-1:0]         r_step;
  logic [2*WIDTH-1:0]    r_y;

  logic                  w_accept;
  logic                  w_last;
  logic [1:0]            w_sel;
  logic [WIDTH:0]        w_sum;
  logic [WIDTH:0]        w_a_sh;
  logic [WIDTH-1:0]      w_q_sh;
  logic                  w_q0_sh;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_step == STEP_LAST);
  assign w_sel    = {r_q[0], r_q0};

  // NOTE: every signal driven here gets a default first, otherwise the uncovered
  // paths would infer latches.
  always_comb begin
    w_sum = r_a;
    case (w_sel)
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
  end

  assign w_a_sh  = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign w_q_sh  = {w_sum[0], r_q[WIDTH-1:1]};
  assign w_q0_sh = r_q[0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_m    <= '0;
      r_q    <= '0;
      r_q0   <= 1'b0;
      r_step <= '0;
      r_y    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_m    <= {a[WIDTH-1], a};
            r_q    <= b;
            r_a    <= '0;
            r_q0   <= 1'b0;
            r_step <= '0;
          end
        end
        S_RUN: begin
          r_a    <= w_a_sh;
          r_q    <= w_q_sh;
          r_q0   <= w_q0_sh;
          r_step <= r_step + SW'(1);
          // The product fits in 2*WIDTH bits, so the guard bit of A is dropped.
          if (w_last) begin
            r_y <= {w_a_sh[WIDTH-1:0], w_q_sh};
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_step <= '0;
          end
        end
        default: begin
          r_step <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign y         = r_y;
  assign step      = r_step;

endmodule
